// File: rtl/audio_udp_packer.sv
// audio_udp_packer: gathers per-channel audio samples into complete sample
// sets, packs FRAME_SAMPLES sets plus a 16-bit sequence number into one of
// two ping-pong packet buffers, and offers full buffers to a UDP sink with a
// valid/ready handshake. Sets that arrive while both buffers are full are
// dropped and counted.
module audio_udp_packer #(
    parameter int CH_NUM        = 2,
    parameter int SAMPLE_W      = 16,
    parameter int FRAME_SAMPLES = 30,
    localparam int PKT_W        = CH_NUM * FRAME_SAMPLES * SAMPLE_W + 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         capture_en,
    input  logic [CH_NUM*SAMPLE_W-1:0]   wav_in_data,
    input  logic [CH_NUM-1:0]            wav_wren,
    output logic                         udp_send_data_valid,
    input  logic                         udp_send_data_ready,
    output logic [PKT_W-1:0]             udp_send_data,
    output logic [15:0]                  udp_send_data_length,
    output logic [15:0]                  drop_cnt,
    output logic                         overflow
);

    localparam int IDX_W = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_SAMPLES - 1);

    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_FILLING = 2'd1,
        B_FULL    = 2'd2
    } bstate_t;

    // Per-channel sample capture
    logic [SAMPLE_W-1:0] samp_q [CH_NUM];
    logic [SAMPLE_W-1:0] samp_d [CH_NUM];
    logic [CH_NUM-1:0]   pend_q, pend_d;

    // Ping-pong packet buffers
    logic [PKT_W-1:0]    buf_q [2];
    logic [PKT_W-1:0]    buf_d [2];
    bstate_t             bst_q [2];
    bstate_t             bst_d [2];
    logic                fill_sel_q, fill_sel_d;   // buffer that receives the next commit
    logic                send_sel_q, send_sel_d;   // oldest full buffer, offered next
    logic [IDX_W-1:0]    set_idx_q, set_idx_d;
    logic [15:0]         seq_q, seq_d;

    // Output side
    logic                valid_q, valid_d;
    logic [PKT_W-1:0]    data_q, data_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                overflow_q, overflow_d;

    // Combinational helpers
    logic [CH_NUM-1:0]   strobe_s;
    logic                complete_s;
    logic                accept_s;
    logic                xfer_s;
    logic [SAMPLE_W-1:0] commit_val_s [CH_NUM];

    // Qualify strobes, detect set completion and pick each channel's committed value
    always_comb begin
        strobe_s   = capture_en ? wav_wren : {CH_NUM{1'b0}};
        complete_s = capture_en & (&(pend_q | strobe_s));
        // the fill buffer may only take a set if it is not still holding a full packet
        accept_s   = (bst_q[fill_sel_q] != B_FULL);
        xfer_s     = valid_q & udp_send_data_ready;
        for (int c = 0; c < CH_NUM; c++) begin
            // an already-pending channel contributes its held sample; a fresh strobe
            // on that channel belongs to the following set
            if (pend_q[c]) begin
                commit_val_s[c] = samp_q[c];
            end else begin
                commit_val_s[c] = wav_in_data[c*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Next-state logic: capture, commit, drop, discard and packet hand-off
    always_comb begin
        samp_d     = samp_q;
        pend_d     = pend_q;
        buf_d      = buf_q;
        bst_d      = bst_q;
        fill_sel_d = fill_sel_q;
        send_sel_d = send_sel_q;
        set_idx_d  = set_idx_q;
        seq_d      = seq_q;
        valid_d    = valid_q;
        data_d     = data_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;

        for (int c = 0; c < CH_NUM; c++) begin
            if (strobe_s[c]) begin
                samp_d[c] = wav_in_data[c*SAMPLE_W +: SAMPLE_W];
            end else begin
                samp_d[c] = samp_q[c];
            end
        end

        if (!capture_en) begin
            pend_d = {CH_NUM{1'b0}};
        end else if (complete_s) begin
            pend_d = strobe_s & pend_q;
        end else begin
            pend_d = pend_q | strobe_s;
        end

        if (complete_s && accept_s) begin
            for (int k = 0; k < FRAME_SAMPLES; k++) begin
                if (set_idx_q == IDX_W'(k)) begin
                    for (int c = 0; c < CH_NUM; c++) begin
                        buf_d[fill_sel_q][PKT_W-1-(k*CH_NUM+c)*SAMPLE_W -: SAMPLE_W] = commit_val_s[c];
                    end
                end else begin
                end
            end
            if (set_idx_q == LAST_IDX) begin
                buf_d[fill_sel_q][15:0] = seq_q;
                bst_d[fill_sel_q]       = B_FULL;
                seq_d                   = seq_q + 16'd1;
                set_idx_d               = {IDX_W{1'b0}};
                fill_sel_d              = ~fill_sel_q;
            end else begin
                bst_d[fill_sel_q]       = B_FILLING;
                set_idx_d               = set_idx_q + IDX_W'(1);
            end
        end else if (complete_s) begin
            drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : (drop_cnt_q + 16'd1);
            overflow_d = 1'b1;
        end else begin
        end

        // capture disabled: throw away any partially filled frame
        if (!capture_en) begin
            set_idx_d = {IDX_W{1'b0}};
            for (int b = 0; b < 2; b++) begin
                if (bst_q[b] == B_FILLING) begin
                    bst_d[b] = B_EMPTY;
                end else begin
                end
            end
        end else begin
        end

        // hand-off: a transfer frees the offered buffer and immediately
        // offers the other one if it is already full
        if (xfer_s) begin
            bst_d[send_sel_q] = B_EMPTY;
            send_sel_d        = ~send_sel_q;
            if (bst_q[~send_sel_q] == B_FULL) begin
                valid_d = 1'b1;
                data_d  = buf_q[~send_sel_q];
            end else begin
                valid_d = 1'b0;
            end
        end else if (!valid_q && (bst_q[send_sel_q] == B_FULL)) begin
            valid_d = 1'b1;
            data_d  = buf_q[send_sel_q];
        end else begin
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH_NUM; c++) begin
                samp_q[c] <= {SAMPLE_W{1'b0}};
            end
            for (int b = 0; b < 2; b++) begin
                buf_q[b] <= {PKT_W{1'b0}};
                bst_q[b] <= B_EMPTY;
            end
            pend_q     <= {CH_NUM{1'b0}};
            fill_sel_q <= 1'b0;
            send_sel_q <= 1'b0;
            set_idx_q  <= {IDX_W{1'b0}};
            seq_q      <= 16'd0;
            valid_q    <= 1'b0;
            data_q     <= {PKT_W{1'b0}};
            drop_cnt_q <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            samp_q     <= samp_d;
            buf_q      <= buf_d;
            bst_q      <= bst_d;
            pend_q     <= pend_d;
            fill_sel_q <= fill_sel_d;
            send_sel_q <= send_sel_d;
            set_idx_q  <= set_idx_d;
            seq_q      <= seq_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Drive ports straight from registers
    always_comb begin
        udp_send_data_valid  = valid_q;
        udp_send_data        = data_q;
        udp_send_data_length = 16'(PKT_W / 8);
        drop_cnt             = drop_cnt_q;
        overflow             = overflow_q;
    end

endmodule

// File: doc/audio_udp_packer.md
AUDIO_UDP_PACKER -- requirements
Module: audio_udp_packer

Interface
REQ-001 SHALL have parameter CH_NUM, default 2, number of audio channels, legal range 1..4.
REQ-002 SHALL have parameter SAMPLE_W, default 16, bits per sample; SAMPLE_W SHALL be a multiple of 8.
REQ-003 SHALL have parameter FRAME_SAMPLES, default 30, sample sets per packet.
REQ-004 SHALL define the derived constant PKT_W = CH_NUM*FRAME_SAMPLES*SAMPLE_W + 16.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port capture_en, input, 1, capture enable.
REQ-008 SHALL have port wav_in_data, input, CH_NUM*SAMPLE_W, per-channel samples; channel c occupies bits [c*SAMPLE_W +: SAMPLE_W].
REQ-009 SHALL have port wav_wren, input, CH_NUM, per-channel one-cycle sample strobes.
REQ-010 SHALL have port udp_send_data_valid, output, 1, packet available.
REQ-011 SHALL have port udp_send_data_ready, input, 1, sink accepts the packet.
REQ-012 SHALL have port udp_send_data, output, PKT_W, packet payload.
REQ-013 SHALL have port udp_send_data_length, output, 16, payload length in bytes, constant PKT_W/8.
REQ-014 SHALL have port drop_cnt, output, 16, count of dropped sample sets.
REQ-015 SHALL have port overflow, output, 1, sticky drop flag.

Function
REQ-016 SHALL hold per channel a sample register and a pending bit; on wav_wren[c] the register SHALL load and pending[c] SHALL set, and a repeat strobe before set completion SHALL overwrite the register.
REQ-017 SHALL complete a sample set on the edge where every pending bit is set or being set; the complete set SHALL commit and all pending bits clear on that edge.
REQ-018 SHALL, when a channel strobes in the cycle a set completes without being part of it, set that channel's pending bit for the next set.
REQ-019 SHALL use two packet buffers (ping-pong), each in state EMPTY, FILLING or FULL.
REQ-020 SHALL write set k (0..FRAME_SAMPLES-1), channel c, into the FILLING buffer at word index w = k*CH_NUM + c, bits [PKT_W-1-w*SAMPLE_W -: SAMPLE_W] (first sample at MSB).
REQ-021 SHALL, on the commit of set FRAME_SAMPLES-1, place the 16-bit sequence number in bits [15:0], mark the buffer FULL, increment the sequence number modulo 2^16, and reset the set index to 0.
REQ-022 SHALL select the other buffer for FILLING on the next commit if it is EMPTY.
REQ-023 SHALL assert udp_send_data_valid exactly one clock after the edge that marks a buffer FULL, provided no packet is currently being offered.
REQ-024 SHALL hold udp_send_data stable while valid is high and ready is low.
REQ-025 SHALL transfer on valid&ready, returning that buffer to EMPTY on that edge.
REQ-026 SHALL offer the other buffer, if FULL, on the next cycle, so valid stays high; buffers SHALL be offered in fill order.
REQ-027 SHALL drop a set that completes when no buffer is FILLING or EMPTY (both FULL).
REQ-028 SHALL, on such a drop, increment drop_cnt saturating at 16'hFFFF and set overflow; the set index SHALL be unchanged.
REQ-029 SHALL, when capture_en is low, ignore wav_wren, clear the pending bits, and discard any partial frame by resetting the set index to 0 and returning a FILLING buffer to EMPTY.
REQ-030 SHALL continue to offer FULL buffers while capture_en is low.
REQ-031 SHALL free a buffer when transfer and commit fall on the same edge, and that buffer SHALL be usable for FILLING on the next commit, not the same edge.

Reset
REQ-032 SHALL, on rst, asynchronously force: valid=0, udp_send_data=0, drop_cnt=0, overflow=0, sequence number=0, set index=0, pending=0, both buffers EMPTY, buffer 0 next to fill.
REQ-033 SHALL let rst mid-packet discard all buffered data with no partial packet emitted after release.
REQ-034 SHALL hold udp_send_data_length constant PKT_W/8 in and out of reset.

Verification (CH_NUM=2, SAMPLE_W=16, FRAME_SAMPLES=4, PKT_W=144, length=18)
REQ-035 SHALL check: ready=1, 4 sets ch0=16'h0100+k, ch1=16'h0200+k -> valid one clock after 4th commit; data=0100_0200_0101_0201_0102_0202_0103_0203_0000.
REQ-036 SHALL check: ch0 strobed twice (A then B) before ch1 -> set holds B, one set committed, not two.
REQ-037 SHALL check: ready=0, 12 sets -> 2 packets buffered, 4 sets dropped, drop_cnt=4, overflow=1; then ready=1 -> packets seq 0 and seq 1 on consecutive cycles.
REQ-038 SHALL check: 66000 packets -> sequence wraps FFFF->0000; drop_cnt saturation forced to FFFF stays FFFF.
REQ-039 SHALL check: capture_en low after 2 sets, then high, then 4 sets -> single packet containing only the last 4 sets.
REQ-040 SHALL check: rst pulse while valid=1 -> valid=0 immediately (asynchronous), next packet seq=0000.
